wspr_symbol_scheduler: RTL and testbench
========================================

# wspr_symbol_scheduler

Transmit-side controller for the NCO/sequencer datapath, running in the clk25MHz domain. Holds the 162-symbol WSPR message and arms on a software start command. Begins a transmission on the next GNSS PPS tick and emits one NCO tuning word per symbol (base + tone × step) at a calibrated symbol period. Gates the PA drive with lead/tail guard intervals so keying never coincides with a frequency change.

## Interface
- GUARD_TICKS, 25000: PA lead/tail guard length in clk25MHz cycles (1 ms).
- PERIOD_W, 25: width of the symbol-period register.
- clk25MHz  in  1  TCXO clock; the only clock.
- resetN  in  1  asynchronous, active-low reset.
- ppsTick  in  1  one-cycle pulse, already synchronized to clk25MHz.
- symWrEn  in  1  symbol-RAM write strobe.
- symWrAddr  in  8  symbol index, 0..161.
- symWrData  in  2  4-FSK tone, 0..3.
- baseTw  in  32  tuning word for tone 0.
- toneStep  in  32  tuning-word increment per tone (≈1.4648 Hz).
- symbolPeriod  in  PERIOD_W  clk25MHz cycles per symbol, nominally 17066667 (PPS-calibrated).
- start  in  1  pulse; arms the scheduler.
- abort  in  1  pulse; ends any activity.
- tuningWord  out  32  NCO tuning word (feeds the tuning-word shadow).
- twValid  out  1  one-cycle pulse when tuningWord changes.
- txEnable  out  1  PA drive gate.
- busy  out  1  high whenever the state is not IDLE.
- symbolIndex  out  8  symbol currently transmitted.
- done  out  1  one-cycle pulse at transmission end.
- aborted  out  1  sticky; set by abort, cleared by start.

## Operation
- Reset values: all outputs 0. State IDLE. RAM contents undefined.
- States and transitions:
  - IDLE: `start` → ARM.
  - ARM: `ppsTick` → LEAD; `abort` → IDLE.
  - LEAD: after GUARD_TICKS → SEND; `abort` → TAIL.
  - SEND: after symbol 161's period → TAIL; `abort` → TAIL.
  - TAIL: after GUARD_TICKS → IDLE with `done`.
- ARM→LEAD actions:
  - latch symbolPeriod, clamping values < 2 to 2;
  - latch baseTw and toneStep;
  - set symbolIndex = 0;
  - load tuningWord for symbol 0 and pulse twValid.
- LEAD: txEnable stays 0 for exactly GUARD_TICKS cycles. Then txEnable = 1, enter SEND, and the period counter starts.
- SEND: the period counter loads latchedPeriod−1 and counts down. On reaching 0:
  - if symbolIndex < 161: symbolIndex++ and the next tuningWord is loaded with a twValid pulse;
  - else go to TAIL.
- TAIL: txEnable = 0 on entry; tuningWord is held. After GUARD_TICKS:
  - tuningWord = 0 and twValid pulses;
  - `done` pulses and the state returns to IDLE.
- Arithmetic: tuningWord = latchedBase + tone × latchedStep, computed modulo 2^32. tone × step is (step<<1 if tone[1]) + (step if tone[0]); overflow wraps silently.
- Symbol writes:
  - accepted only in IDLE;
  - ignored when busy or when symWrAddr ≥ 162;
  - a read and a write to the same address in one cycle is impossible because writes are gated to IDLE.
- Priority: `abort` beats `start` and `ppsTick` in the same cycle. `start` while busy is ignored.
- Abort in LEAD or SEND:
  - enters TAIL next cycle with txEnable = 0;
  - `aborted` is set;
  - `done` still pulses at TAIL end.
- Abort in ARM: returns to IDLE, sets `aborted`, and `done` does not pulse.
- Async reset mid-transmission: immediate return to reset values, including txEnable = 0.

## Timing
- Outputs are registered.
- tuningWord/twValid change 1 cycle after the causing event. Events are the ppsTick sample or period-counter terminal count.
- The RAM read is synchronous, so the next symbol's tone is prefetched during the current period to meet this 1-cycle latency.
- Frequency changes happen only while txEnable is stable:
  - first twValid precedes txEnable↑ by GUARD_TICKS cycles;
  - last symbol change precedes txEnable↓ by exactly one symbol period;
  - the tuningWord-to-0 update follows txEnable↓ by GUARD_TICKS cycles.
- Each symbol lasts exactly latchedPeriod cycles.
- Total SEND duration is 162 × latchedPeriod cycles.
- busy rises the cycle after `start` and falls with the `done` cycle.

## Structure
- Package wspr_pkg:
  - NUM_SYMBOLS = 162;
  - tone_t (logic [1:0]);
  - sched_state_t enum {IDLE, ARM, LEAD, SEND, TAIL}.
- Sub-module wspr_symbol_ram: 162×2 single-port-write / single-port-read RAM, synchronous read, maps to one SB_RAM40_4K.
- Top-level block contents:
  - the state machine;
  - the period counter;
  - the guard counter (shares width with the period counter);
  - the tone multiply-add.

## Test plan
All scenarios use GUARD_TICKS = 4 and symbolPeriod = 10.
- Full run: RAM filled with tones (i mod 4), baseTw = 0x1000, toneStep = 0x10, start, then ppsTick.
  - 162 twValid pulses with words 0x1000, 0x1010, 0x1020, 0x1030, …, spaced 10 cycles;
  - txEnable high for 1620 cycles;
  - done pulses 4 cycles after txEnable↓, then tuningWord = 0.
- ARM wait: start with no ppsTick for 1000 cycles → busy = 1, txEnable = 0, no twValid. ppsTick → first twValid 1 cycle later.
- Abort at symbol 50 → txEnable = 0 next cycle, aborted = 1, done 4 cycles later, symbolIndex frozen at 50.
- Abort + ppsTick in the same ARM cycle → IDLE, no twValid, aborted = 1, done never pulses.
- Writes during SEND to address 5 and writes to address 200 in IDLE → RAM unchanged, verified by a second run.
- Edge values:
  - symbolPeriod = 0 → each symbol lasts 2 cycles;
  - baseTw = 0xFFFF_FFF0 with toneStep = 0x10, tone 3 → tuningWord = 0x0000_0020 (wrap).

Source files
------------

// File: rtl/wspr_pkg.sv
// Shared types and helpers for the WSPR transmit scheduler.
package wspr_pkg;

   localparam int NUM_SYMBOLS = 162;

   typedef logic [1:0] tone_t;

   typedef enum logic [2:0] {IDLE, ARM, LEAD, SEND, TAIL} sched_state_t;

   // base + tone*step using shift-add; wraps modulo 2^32
   function automatic logic [31:0] tone_word(input logic [31:0] base,
                                             input logic [31:0] step,
                                             input tone_t       tone);
      logic [31:0] acc;
      acc = base;
      if (tone[1]) acc = acc + {step[30:0], 1'b0};
      if (tone[0]) acc = acc + step;
      return acc;
   endfunction

endpackage

// File: rtl/wspr_symbol_ram.sv
// 162 x 2-bit symbol store; one write port, one synchronous read port.
module wspr_symbol_ram import wspr_pkg::*; (
   input  logic       clk,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  tone_t      wr_data,
   input  logic [7:0] rd_addr,
   output tone_t      rd_data
);

   tone_t mem [NUM_SYMBOLS];

   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < 8'(NUM_SYMBOLS)))
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/wspr_symbol_scheduler.sv
// WSPR transmit sequencer: PPS-aligned start, per-symbol NCO tuning words, PA keying with guards.
//
// state | meaning
// IDLE  | waiting for start; symbol RAM writable
// ARM   | armed, waiting for the PPS tick
// LEAD  | first tuning word loaded, PA held off for the lead guard
// SEND  | PA keyed, stepping through the 162 symbols
// TAIL  | PA off, holding the last word for the tail guard
module wspr_symbol_scheduler import wspr_pkg::*; #(
   parameter int GUARD_TICKS = 25000,
   parameter int PERIOD_W    = 25
) (
   input  logic                clk25MHz,
   input  logic                resetN,
   input  logic                ppsTick,
   input  logic                symWrEn,
   input  logic [7:0]          symWrAddr,
   input  logic [1:0]          symWrData,
   input  logic [31:0]         baseTw,
   input  logic [31:0]         toneStep,
   input  logic [PERIOD_W-1:0] symbolPeriod,
   input  logic                start,
   input  logic                abort,
   output logic [31:0]         tuningWord,
   output logic                twValid,
   output logic                txEnable,
   output logic                busy,
   output logic [7:0]          symbolIndex,
   output logic                done,
   output logic                aborted
);

   localparam logic [PERIOD_W-1:0] GUARD_LOAD = PERIOD_W'(GUARD_TICKS - 1);
   localparam logic [7:0]          LAST_SYM   = 8'(NUM_SYMBOLS - 1);

   sched_state_t        state, state_next;
   logic [PERIOD_W-1:0] period_cnt, guard_cnt, lat_period;
   logic [31:0]         lat_base, lat_step;
   logic [7:0]          rd_addr;
   tone_t               rd_tone;
   logic                period_tc, guard_tc;
   logic                launch, advance, finish, kill, guard_load, period_load;

   assign period_tc = (period_cnt == '0);
   assign guard_tc  = (guard_cnt == '0);

   wspr_symbol_ram u_ram (
      .clk     (clk25MHz),
      .wr_en   (symWrEn && (state == IDLE)),
      .wr_addr (symWrAddr),
      .wr_data (symWrData),
      .rd_addr (rd_addr),
      .rd_data (rd_tone)
   );

   always_ff @(posedge clk25MHz or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      kill       = 1'b0;
      case (state)
         IDLE: if (start && !abort) state_next = ARM;
         ARM: begin
            if (abort) begin
               state_next = IDLE;
               kill       = 1'b1;
            end else if (ppsTick) begin
               state_next = LEAD;
               launch     = 1'b1;
            end
         end
         LEAD: begin
            if (abort) begin
               state_next = TAIL;
               kill       = 1'b1;
            end else if (guard_tc) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (abort) begin
               state_next = TAIL;
               kill       = 1'b1;
            end else if (period_tc) begin
               if (symbolIndex == LAST_SYM) state_next = TAIL;
               else                         advance    = 1'b1;
            end
         end
         TAIL: begin
            if (guard_tc) begin
               state_next = IDLE;
               finish     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Prefetch the next symbol's tone so it is ready at terminal count.
   always_comb begin
      rd_addr = 8'd0;
      if ((state == LEAD) || (state == SEND))
         rd_addr = (symbolIndex == LAST_SYM) ? LAST_SYM : symbolIndex + 8'd1;
   end

   assign guard_load  = ((state_next == LEAD) && (state != LEAD)) ||
                        ((state_next == TAIL) && (state != TAIL));
   assign period_load = ((state == LEAD) && (state_next == SEND)) || advance;

   always_ff @(posedge clk25MHz or negedge resetN) begin
      if (!resetN) begin
         guard_cnt  <= '0;
         period_cnt <= '0;
      end else begin
         if (guard_load)     guard_cnt <= GUARD_LOAD;
         else if (!guard_tc) guard_cnt <= guard_cnt - PERIOD_W'(1);
         if (period_load)
            period_cnt <= lat_period - PERIOD_W'(1);
         else if ((state == SEND) && !period_tc)
            period_cnt <= period_cnt - PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk25MHz or negedge resetN) begin
      if (!resetN) begin
         lat_period  <= '0;
         lat_base    <= '0;
         lat_step    <= '0;
         tuningWord  <= '0;
         twValid     <= 1'b0;
         txEnable    <= 1'b0;
         busy        <= 1'b0;
         symbolIndex <= '0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         twValid  <= 1'b0;
         done     <= 1'b0;
         txEnable <= (state_next == SEND);
         busy     <= (state_next != IDLE);
         if (launch) begin
            lat_period  <= (symbolPeriod < PERIOD_W'(2)) ? PERIOD_W'(2) : symbolPeriod;
            lat_base    <= baseTw;
            lat_step    <= toneStep;
            symbolIndex <= 8'd0;
            tuningWord  <= tone_word(baseTw, toneStep, rd_tone);
            twValid     <= 1'b1;
         end
         if (advance) begin
            symbolIndex <= symbolIndex + 8'd1;
            tuningWord  <= tone_word(lat_base, lat_step, rd_tone);
            twValid     <= 1'b1;
         end
         if (finish) begin
            tuningWord <= '0;
            twValid    <= 1'b1;
            done       <= 1'b1;
         end
         if (kill)
            aborted <= 1'b1;
         else if ((state == IDLE) && start && !abort)
            aborted <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wspr_symbol_scheduler.sv
// Scoreboard bench for wspr_symbol_scheduler with a short guard and short symbol periods.
module tb_wspr_symbol_scheduler;
   import wspr_pkg::*;

   localparam int G  = 4;
   localparam int PW = 25;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          ppsTick = 1'b0;
   logic          symWrEn = 1'b0;
   logic [7:0]    symWrAddr = '0;
   logic [1:0]    symWrData = '0;
   logic [31:0]   baseTw = '0;
   logic [31:0]   toneStep = '0;
   logic [PW-1:0] symbolPeriod = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [31:0]   tuningWord;
   logic          twValid, txEnable, busy, done, aborted;
   logic [7:0]    symbolIndex;

   wspr_symbol_scheduler #(.GUARD_TICKS(G), .PERIOD_W(PW)) dut (
      .clk25MHz     (clk),
      .resetN       (resetN),
      .ppsTick      (ppsTick),
      .symWrEn      (symWrEn),
      .symWrAddr    (symWrAddr),
      .symWrData    (symWrData),
      .baseTw       (baseTw),
      .toneStep     (toneStep),
      .symbolPeriod (symbolPeriod),
      .start        (start),
      .abort        (abort),
      .tuningWord   (tuningWord),
      .twValid      (twValid),
      .txEnable     (txEnable),
      .busy         (busy),
      .symbolIndex  (symbolIndex),
      .done         (done),
      .aborted      (aborted)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      int          at;
   } exp_t;

   exp_t tw_q[$];
   int   done_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] model_tw(input logic [31:0] b, input logic [31:0] s, input int tone);
      return b + s * 32'(tone);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      int   t;
      if (resetN && twValid) begin
         if (tw_q.size() == 0) begin
            check("tw_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = tw_q.pop_front();
            check("tw_word", tuningWord, e.word);
            check("tw_time", 32'(cyc), 32'(e.at));
         end
      end
      if (resetN && done) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            t = done_q.pop_front();
            check("done_time", 32'(cyc), 32'(t));
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_pps();
      ppsTick = 1'b1;
      @(negedge clk);
      ppsTick = 1'b0;
   endtask

   // symbol 0 appears the cycle after PPS; symbol k>=1 at SEND entry + k*per
   task automatic push_run(input int c, input logic [31:0] b, input logic [31:0] s,
                           input int per, input int last_k);
      for (int k = 0; k <= last_k; k++)
         tw_q.push_back('{word: model_tw(b, s, k % 4),
                          at:   (k == 0) ? c + 1 : c + G + 1 + k * per});
   endtask

   initial begin : watchdog
      #(40 * 20000);
      $display("FAIL watchdog: run did not complete within 20000 cycles");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c, s, x, e;
      symbolPeriod = PW'(10);
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check("rst_tuningWord", tuningWord, 32'h0);
      check("rst_twValid", 32'(twValid), 32'h0);
      check("rst_txEnable", 32'(txEnable), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_symbolIndex", 32'(symbolIndex), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_aborted", 32'(aborted), 32'h0);

      for (int i = 0; i < NUM_SYMBOLS; i++) begin
         symWrEn   = 1'b1;
         symWrAddr = 8'(i);
         symWrData = 2'(i % 4);
         @(negedge clk);
      end
      symWrAddr = 8'd200;
      symWrData = 2'd3;
      @(negedge clk);
      symWrEn = 1'b0;

      // full run, period 10
      baseTw   = 32'h0000_1000;
      toneStep = 32'h0000_0010;
      pulse_start();
      check("run1_busy_rise", 32'(busy), 32'h1);
      check("run1_arm_tx", 32'(txEnable), 32'h0);
      repeat (2) @(negedge clk);
      c = cyc;
      s = c + G + 1;
      e = s + 162 * 10;
      push_run(c, baseTw, toneStep, 10, 161);
      tw_q.push_back('{word: 32'h0, at: e + G});
      done_q.push_back(e + G);
      pulse_pps();
      wait_until(s - 1);
      check("run1_lead_tx_low", 32'(txEnable), 32'h0);
      wait_until(s);
      check("run1_tx_rise", 32'(txEnable), 32'h1);
      wait_until(s + 25);
      symWrEn   = 1'b1;
      symWrAddr = 8'd5;
      symWrData = 2'd3;
      @(negedge clk);
      symWrEn = 1'b0;
      wait_until(e - 1);
      check("run1_tx_last", 32'(txEnable), 32'h1);
      wait_until(e);
      check("run1_tx_fall", 32'(txEnable), 32'h0);
      check("run1_tail_word", tuningWord, model_tw(32'h1000, 32'h10, 161 % 4));
      check("run1_last_index", 32'(symbolIndex), 32'd161);
      wait_until(e + G - 1);
      check("run1_busy_tail", 32'(busy), 32'h1);
      wait_until(e + G);
      check("run1_busy_fall", 32'(busy), 32'h0);
      check("run1_word_zero", tuningWord, 32'h0);
      repeat (3) @(negedge clk);

      // ARM wait, then abort at symbol 50; also confirms RAM untouched at 5
      pulse_start();
      repeat (1000) @(negedge clk);
      check("arm_busy", 32'(busy), 32'h1);
      check("arm_tx", 32'(txEnable), 32'h0);
      c = cyc;
      push_run(c, baseTw, toneStep, 10, 50);
      x = c + G + 1 + 500 + 3;
      tw_q.push_back('{word: 32'h0, at: x + 1 + G});
      done_q.push_back(x + 1 + G);
      pulse_pps();
      wait_until(x);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_tx_off", 32'(txEnable), 32'h0);
      check("abort_sticky", 32'(aborted), 32'h1);
      check("abort_index", 32'(symbolIndex), 32'd50);
      wait_until(x + 1 + G);
      check("abort_busy_fall", 32'(busy), 32'h0);
      check("abort_index_frozen", 32'(symbolIndex), 32'd50);
      repeat (3) @(negedge clk);

      // abort and PPS together while armed
      pulse_start();
      check("start_clears_aborted", 32'(aborted), 32'h0);
      repeat (3) @(negedge clk);
      abort   = 1'b1;
      ppsTick = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      ppsTick = 1'b0;
      check("armabort_busy", 32'(busy), 32'h0);
      check("armabort_aborted", 32'(aborted), 32'h1);
      check("armabort_tx", 32'(txEnable), 32'h0);
      repeat (30) @(negedge clk);
      check("armabort_idle", 32'(busy), 32'h0);

      // period 0 clamps to 2; base wraps past 2^32
      baseTw       = 32'hFFFF_FFF0;
      toneStep     = 32'h0000_0010;
      symbolPeriod = '0;
      pulse_start();
      check("edge_aborted_clr", 32'(aborted), 32'h0);
      repeat (2) @(negedge clk);
      c = cyc;
      s = c + G + 1;
      e = s + 162 * 2;
      push_run(c, baseTw, toneStep, 2, 161);
      tw_q.push_back('{word: 32'h0, at: e + G});
      done_q.push_back(e + G);
      pulse_pps();
      wait_until(s + 3 * 2);
      check("edge_wrap_tone3", tuningWord, 32'h0000_0020);
      wait_until(e - 1);
      check("edge_tx_last", 32'(txEnable), 32'h1);
      wait_until(e);
      check("edge_tx_fall", 32'(txEnable), 32'h0);
      wait_until(e + G + 2);

      for (int i = 0; i < 50; i++) begin
         if (tw_q.size() == 0 && done_q.size() == 0) break;
         @(negedge clk);
      end
      check("tw_queue_drained", 32'(tw_q.size()), 32'h0);
      check("done_queue_drained", 32'(done_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
